// File: rtl/imm_extend_pipe_pkg.sv
// ============================================================================
// Module : imm_pkg
// Brief  : Immediate modes and instruction field positions for imm_extend_pipe
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I   = 3'd0,
      IMM_D   = 3'd1,
      IMM_B   = 3'd2,
      IMM_CB  = 3'd3,
      IMM_MOV = 3'd4
   } imm_mode_t;

   localparam int c_I_LSB      = 10;
   localparam int c_I_MSB      = 21;
   localparam int c_D_LSB      = 12;
   localparam int c_D_MSB      = 20;
   localparam int c_B_LSB      = 0;
   localparam int c_B_MSB      = 25;
   localparam int c_CB_LSB     = 5;
   localparam int c_CB_MSB     = 23;
   localparam int c_MOV_LSB    = 5;
   localparam int c_MOV_MSB    = 20;
   localparam int c_MOV_HW_LSB = 21;
   localparam int c_MOV_HW_MSB = 22;

   function automatic int field_w(input int msb, input int lsb);
      return msb - lsb + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/imm_extend_pipe_if.sv
// ============================================================================
// Module : imm_extend_pipe_if
// Brief  : Input and output valid/ready channels of imm_extend_pipe
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface imm_extend_pipe_if #(
   parameter int DATA_W = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [2:0]        mode;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] imm;
   logic              err;

   modport slave (
      input  in_valid, instr, mode, out_ready,
      output in_ready, out_valid, imm, err
   );

   modport master (
      output in_valid, instr, mode, out_ready,
      input  in_ready, out_valid, imm, err
   );
endinterface

`default_nettype wire

// File: rtl/imm_extend_pipe_ext_field.sv
// ============================================================================
// Module : ext_field
// Brief  : Sign or zero extension of an IN_W-bit field to OUT_W bits
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ext_field #(
   parameter int IN_W   = 12,
   parameter int OUT_W  = 64,
   parameter bit SIGNED = 1'b0
) (
   input  wire logic [IN_W-1:0]  i_field,
   output logic      [OUT_W-1:0] o_ext
);

   if (SIGNED) begin : g_sext
      assign o_ext = {{(OUT_W-IN_W){i_field[IN_W-1]}}, i_field};
   end else begin : g_zext
      assign o_ext = {{(OUT_W-IN_W){1'b0}}, i_field};
   end

endmodule

`default_nettype wire

// File: rtl/imm_extend_pipe.sv
// ============================================================================
// Module : imm_extend_pipe
// Brief  : Mode-selected immediate extend/shift, buffered in a small FIFO
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_extend_pipe #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2
) (
   input wire logic          clk,
   input wire logic          reset_n,
   imm_extend_pipe_if.slave  bus
);
   import imm_pkg::*;

   localparam int c_PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CW     = $clog2(DEPTH + 1);
   localparam int c_MAX_HW = DATA_W / 16 - 1;

   if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("imm_extend_pipe: DATA_W must be 32 or 64");
   end
   if (DEPTH < 2 || DEPTH > 4) begin : g_bad_depth
      $error("imm_extend_pipe: DEPTH must be 2..4");
   end

   logic [DATA_W-1:0] w_ext_i, w_ext_d, w_ext_b, w_ext_cb, w_ext_mov;
   logic [DATA_W-1:0] w_imm;
   logic              w_err;
   logic [1:0]        w_hw;
   logic              w_push, w_pop;
   logic [c_PW-1:0]   w_wptr_nxt, w_rptr_nxt;
   logic              w_unused;

   logic [DEPTH-1:0][DATA_W-1:0] r_mem_imm;
   logic [DEPTH-1:0]             r_mem_err;
   logic [c_PW-1:0]              r_wptr, r_rptr;
   logic [c_CW-1:0]              r_count;

   ext_field #(.IN_W(field_w(c_I_MSB, c_I_LSB)), .OUT_W(DATA_W), .SIGNED(1'b0)) u_ext_i (
      .i_field (bus.instr[c_I_MSB:c_I_LSB]),
      .o_ext   (w_ext_i)
   );
   ext_field #(.IN_W(field_w(c_D_MSB, c_D_LSB)), .OUT_W(DATA_W), .SIGNED(1'b1)) u_ext_d (
      .i_field (bus.instr[c_D_MSB:c_D_LSB]),
      .o_ext   (w_ext_d)
   );
   ext_field #(.IN_W(field_w(c_B_MSB, c_B_LSB)), .OUT_W(DATA_W), .SIGNED(1'b1)) u_ext_b (
      .i_field (bus.instr[c_B_MSB:c_B_LSB]),
      .o_ext   (w_ext_b)
   );
   ext_field #(.IN_W(field_w(c_CB_MSB, c_CB_LSB)), .OUT_W(DATA_W), .SIGNED(1'b1)) u_ext_cb (
      .i_field (bus.instr[c_CB_MSB:c_CB_LSB]),
      .o_ext   (w_ext_cb)
   );
   ext_field #(.IN_W(field_w(c_MOV_MSB, c_MOV_LSB)), .OUT_W(DATA_W), .SIGNED(1'b0)) u_ext_mov (
      .i_field (bus.instr[c_MOV_MSB:c_MOV_LSB]),
      .o_ext   (w_ext_mov)
   );

   assign w_hw     = bus.instr[c_MOV_HW_MSB:c_MOV_HW_LSB];
   assign w_unused = ^bus.instr[31:26];

   // A MOV halfword that would land beyond the result width is flagged, not truncated
   always_comb begin
      w_imm = '0;
      w_err = 1'b0;
      case (bus.mode)
         IMM_I:   w_imm = w_ext_i;
         IMM_D:   w_imm = w_ext_d;
         IMM_B:   w_imm = w_ext_b << 2;
         IMM_CB:  w_imm = w_ext_cb << 2;
         IMM_MOV: begin
            if ({30'd0, w_hw} > 32'(c_MAX_HW)) begin
               w_err = 1'b1;
            end else begin
               w_imm = w_ext_mov << {w_hw, 4'b0000};
            end
         end
         default: w_err = 1'b1;
      endcase
   end

   assign bus.in_ready  = (r_count < c_CW'(DEPTH));
   assign bus.out_valid = (r_count != '0);
   assign bus.imm       = r_mem_imm[r_rptr];
   assign bus.err       = r_mem_err[r_rptr];

   assign w_push = bus.in_valid && bus.in_ready;
   assign w_pop  = bus.out_valid && bus.out_ready;

   assign w_wptr_nxt = (r_wptr == c_PW'(DEPTH - 1)) ? '0 : r_wptr + c_PW'(1);
   assign w_rptr_nxt = (r_rptr == c_PW'(DEPTH - 1)) ? '0 : r_rptr + c_PW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_imm <= '0;
         r_mem_err <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
      end else begin
         if (w_push) begin
            r_mem_imm[r_wptr] <= w_imm;
            r_mem_err[r_wptr] <= w_err;
            r_wptr            <= w_wptr_nxt;
         end
         if (w_pop) begin
            r_rptr <= w_rptr_nxt;
         end
         r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
// ============================================================================
// Module : tb_imm_extend_pipe
// Brief  : Self-checking bench for 64- and 32-bit imm_extend_pipe instances
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_extend_pipe;

   logic clk;
   logic reset_n;

   logic        cur_valid;
   logic [31:0] cur_instr;
   logic [2:0]  cur_mode;
   logic        cur_ordy;

   int n_tests;
   int n_fail;
   int n_pop;

   logic [64:0] q64[$];
   logic [64:0] q32[$];

   imm_extend_pipe_if #(.DATA_W(64)) if64 ();
   imm_extend_pipe_if #(.DATA_W(32)) if32 ();

   assign if64.in_valid  = cur_valid;
   assign if64.instr     = cur_instr;
   assign if64.mode      = cur_mode;
   assign if64.out_ready = cur_ordy;
   assign if32.in_valid  = cur_valid;
   assign if32.instr     = cur_instr;
   assign if32.mode      = cur_mode;
   assign if32.out_ready = cur_ordy;

   imm_extend_pipe #(.DATA_W(64), .DEPTH(2)) u_dut64 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if64)
   );

   imm_extend_pipe #(.DATA_W(32), .DEPTH(2)) u_dut32 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {err, imm} straight from the field rules, masked to dw bits
   function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] md, input int dw);
      logic signed [63:0] s;
      logic [63:0] v;
      logic e;
      int hw;
      v = '0;
      e = 1'b0;
      case (md)
         3'd0: v = 64'(ins[21:10]);
         3'd1: begin s = $signed(ins[20:12]); v = s; end
         3'd2: begin s = $signed(ins[25:0]); v = s * 4; end
         3'd3: begin s = $signed(ins[23:5]); v = s * 4; end
         3'd4: begin
            hw = int'(ins[22:21]);
            if (16 * hw + 16 > dw) e = 1'b1;
            else v = 64'(ins[20:5]) * (64'd1 << (16 * hw));
         end
         default: e = 1'b1;
      endcase
      if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return {e, v};
   endfunction

   // One clock of traffic: compare both DUTs with the queue model, then advance
   task automatic step();
      logic [64:0] h;
      logic push, pop;
      n_tests++;
      if (if64.in_ready !== (q64.size() < 2)) begin
         n_fail++; $display("FAIL in_ready64: got %b want %b", if64.in_ready, q64.size() < 2);
      end
      n_tests++;
      if (if32.in_ready !== (q32.size() < 2)) begin
         n_fail++; $display("FAIL in_ready32: got %b want %b", if32.in_ready, q32.size() < 2);
      end
      n_tests++;
      if (if64.out_valid !== (q64.size() != 0)) begin
         n_fail++; $display("FAIL out_valid64: got %b want %b", if64.out_valid, q64.size() != 0);
      end
      n_tests++;
      if (if32.out_valid !== (q32.size() != 0)) begin
         n_fail++; $display("FAIL out_valid32: got %b want %b", if32.out_valid, q32.size() != 0);
      end
      if (q64.size() != 0) begin
         h = q64[0];
         n_tests++;
         if ({if64.err, if64.imm} !== h) begin
            n_fail++; $display("FAIL head64: got err=%b imm=%h want err=%b imm=%h",
                               if64.err, if64.imm, h[64], h[63:0]);
         end
      end
      if (q32.size() != 0) begin
         h = q32[0];
         n_tests++;
         if ({if32.err, if32.imm} !== {h[64], h[31:0]}) begin
            n_fail++; $display("FAIL head32: got err=%b imm=%h want err=%b imm=%h",
                               if32.err, if32.imm, h[64], h[31:0]);
         end
      end
      push = cur_valid && (q64.size() < 2);
      pop  = cur_ordy && (q64.size() != 0);
      @(posedge clk);
      if (pop) begin
         void'(q64.pop_front());
         void'(q32.pop_front());
         n_pop++;
      end
      if (push) begin
         q64.push_back(model(cur_instr, cur_mode, 64));
         q32.push_back(model(cur_instr, cur_mode, 32));
      end
      @(negedge clk);
   endtask

   task automatic drive_one(input logic [31:0] ins, input logic [2:0] md);
      cur_instr = ins;
      cur_mode  = md;
      cur_valid = 1'b1;
      cur_ordy  = 1'b1;
      step();
      cur_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++;
      if (if64.out_valid !== 1'b0 || if64.imm !== 64'd0 || if64.err !== 1'b0) begin
         n_fail++; $display("FAIL reset_state64: got v=%b imm=%h err=%b want 0", if64.out_valid, if64.imm, if64.err);
      end
      n_tests++;
      if (if32.out_valid !== 1'b0 || if32.imm !== 32'd0 || if32.err !== 1'b0) begin
         n_fail++; $display("FAIL reset_state32: got v=%b imm=%h err=%b want 0", if32.out_valid, if32.imm, if32.err);
      end
      reset_n = 1'b1;
      #1;
      n_tests++;
      if (if64.in_ready !== 1'b1 || if32.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b/%b want 1/1", if64.in_ready, if32.in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] ins;
      ins = $urandom; ins[20:12] = 9'h1FF;
      drive_one(ins, 3'd1);
      n_tests++;
      if (if64.out_valid !== 1'b1 || if64.imm !== 64'hFFFF_FFFF_FFFF_FFFF || if64.err !== 1'b0) begin
         n_fail++; $display("FAIL d_mode: got v=%b imm=%h err=%b want 1 ffffffffffffffff 0", if64.out_valid, if64.imm, if64.err);
      end
      step();
      ins = $urandom; ins[25:0] = 26'h200_0000;
      drive_one(ins, 3'd2);
      n_tests++;
      if (if64.imm !== 64'hFFFF_FFFF_F800_0000 || if64.err !== 1'b0) begin
         n_fail++; $display("FAIL b_mode: got imm=%h err=%b want fffffffff8000000 0", if64.imm, if64.err);
      end
      step();
      ins = $urandom; ins[23:5] = 19'h1;
      drive_one(ins, 3'd3);
      n_tests++;
      if (if64.imm !== 64'd4 || if32.imm !== 32'd4) begin
         n_fail++; $display("FAIL cb_mode: got imm=%h/%h want 4/4", if64.imm, if32.imm);
      end
      step();
      ins = $urandom; ins[20:5] = 16'hABCD; ins[22:21] = 2'd3;
      drive_one(ins, 3'd4);
      n_tests++;
      if (if64.imm !== 64'hABCD_0000_0000_0000 || if64.err !== 1'b0) begin
         n_fail++; $display("FAIL mov_hw3_64: got imm=%h err=%b want abcd000000000000 0", if64.imm, if64.err);
      end
      n_tests++;
      if (if32.imm !== 32'd0 || if32.err !== 1'b1) begin
         n_fail++; $display("FAIL mov_hw3_32: got imm=%h err=%b want 0 1", if32.imm, if32.err);
      end
      step();
      drive_one($urandom, 3'd6);
      n_tests++;
      if (if64.imm !== 64'd0 || if64.err !== 1'b1 || if32.imm !== 32'd0 || if32.err !== 1'b1) begin
         n_fail++; $display("FAIL reserved_mode: got %h/%b %h/%b want 0/1 0/1", if64.imm, if64.err, if32.imm, if32.err);
      end
      step();
   endtask

   task automatic test_backpressure();
      logic [64:0] h0;
      cur_ordy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cur_valid = 1'b1;
         cur_instr = $urandom;
         cur_mode  = 3'($urandom_range(0, 4));
         step();
      end
      n_tests++;
      if (if64.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_full: got in_ready=%b want 0", if64.in_ready);
      end
      h0 = {if64.err, if64.imm};
      for (int k = 0; k < 3; k++) step();
      n_tests++;
      if ({if64.err, if64.imm} !== h0) begin
         n_fail++; $display("FAIL bp_stable: got %h want %h", {if64.err, if64.imm}, h0);
      end
      cur_ordy = 1'b1;
      step();
      step();
      cur_valid = 1'b0;
      step();
      step();
      n_tests++;
      if (if64.out_valid !== 1'b0 || q64.size() != 0) begin
         n_fail++; $display("FAIL bp_drain: got out_valid=%b want 0", if64.out_valid);
      end
   endtask

   task automatic test_streaming();
      int start_pop;
      cur_ordy  = 1'b1;
      start_pop = n_pop;
      for (int k = 0; k < 100; k++) begin
         cur_valid = 1'b1;
         cur_instr = $urandom;
         cur_mode  = 3'($urandom_range(0, 7));
         step();
      end
      cur_valid = 1'b0;
      step();
      step();
      n_tests++;
      if (n_pop - start_pop != 100) begin
         n_fail++; $display("FAIL stream_count: got %0d want 100", n_pop - start_pop);
      end
   endtask

   task automatic test_reset_midstream();
      cur_ordy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cur_valid = 1'b1;
         cur_instr = $urandom;
         cur_mode  = 3'($urandom_range(0, 4));
         step();
      end
      cur_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (if64.out_valid !== 1'b0 || if64.imm !== 64'd0 || if64.err !== 1'b0) begin
         n_fail++; $display("FAIL async_reset64: got v=%b imm=%h err=%b want 0", if64.out_valid, if64.imm, if64.err);
      end
      n_tests++;
      if (if32.out_valid !== 1'b0 || if32.imm !== 32'd0 || if32.err !== 1'b0) begin
         n_fail++; $display("FAIL async_reset32: got v=%b imm=%h err=%b want 0", if32.out_valid, if32.imm, if32.err);
      end
      q64.delete();
      q32.delete();
      @(negedge clk);
      @(negedge clk);
      reset_n   = 1'b1;
      cur_ordy  = 1'b1;
      cur_valid = 1'b1;
      cur_instr = $urandom;
      cur_mode  = 3'($urandom_range(0, 4));
      step();
      cur_valid = 1'b0;
      n_tests++;
      if (if64.out_valid !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_push: got out_valid=%b want 1", if64.out_valid);
      end
      step();
      step();
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      n_pop     = 0;
      reset_n   = 1'b0;
      cur_valid = 1'b0;
      cur_instr = '0;
      cur_mode  = '0;
      cur_ordy  = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_directed();
      test_backpressure();
      test_streaming();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
